// File: rtl/mem_access_stage.sv
// MEM-stage controller: turns EXMEM MemRead/MemWrite into a valid/ready data-memory transaction
// and stalls the pipeline until it completes. Define MEM_ACCESS_STALL_CNT_EN for the stall counter.
module mem_access_stage #(
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] RS2data_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ready_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] MemData_o,
  output logic        Stall_o,
  output logic        Err_o,
  output logic [31:0] StallCnt_o
);

  localparam logic [31:0] MaxWait = 32'(MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mdata_q, mdata_d;
  logic [31:0] wait_q, wait_d;
  logic        err_q, err_d;
  logic        stall;
  logic        req;
  logic [31:0] wait_inc;

  assign wait_inc = wait_q + 32'd1;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mdata_d = mdata_q;
    wait_d  = wait_q;
    err_d   = 1'b0;
    stall   = 1'b0;
    req     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (MemRead_i || MemWrite_i) begin
          stall   = 1'b1;
          we_d    = MemWrite_i;  // read+write together resolves to a write
          addr_d  = ALUResult_i;
          wdata_d = RS2data_i;
          wait_d  = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        stall = 1'b1;
        req   = 1'b1;
        if (dmem_ready_i) begin
          if (!we_q) mdata_d = dmem_rdata_i;
          state_d = StDone;
        end else if ((MaxWait != '0) && (wait_inc == MaxWait)) begin
          if (!we_q) mdata_d = '0;
          wait_d  = MaxWait;
          err_d   = 1'b1;
          state_d = StDone;
        end else if (wait_q != MaxWait) begin
          wait_d = wait_inc;
        end
      end
      StDone: begin
        // Pipeline advances at this edge; never re-examine the same EXMEM entry.
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mdata_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mdata_q <= mdata_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  assign dmem_req_o   = req;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign MemData_o    = mdata_q;
  assign Stall_o      = stall && !rst_i;
  assign Err_o        = err_q;

`ifdef MEM_ACCESS_STALL_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (stall) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign StallCnt_o = cnt_q;
`else
  assign StallCnt_o = '0;
`endif

endmodule
